alu_seq_core: RTL and testbench

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

---
 rtl/alu_seq_core_if.sv | 32 +++
 rtl/alu_seq_core.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - command/operand and result bundle for alu_seq_core
interface alu_seq_core_if #(
    parameter int DW = 8,
    parameter int CW = 4
) ();
    logic            CE;
    logic            MODE;
    logic [CW-1:0]   CMD;
    logic [1:0]      INP_VALID;
    logic [DW-1:0]   OPA;
    logic [DW-1:0]   OPB;
    logic            CIN;
    logic [2*DW-1:0] RES;
    logic            COUT;
    logic            OFLOW;
    logic            G;
    logic            E;
    logic            L;
    logic            ERR;
    logic            OUT_VALID;
    logic            BUSY;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
    );
endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - sequential operand-capturing ALU; multiply enabled by ALU_SEQ_MUL_EN
module alu_seq_core #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input logic          CLK,
    input logic          RST,
    alu_seq_core_if.slave bus
);
    localparam int SW = $clog2(DW);

    localparam logic [CW-1:0] A_ADD  = CW'(0);
    localparam logic [CW-1:0] A_SUB  = CW'(1);
    localparam logic [CW-1:0] A_ADDC = CW'(2);
    localparam logic [CW-1:0] A_SUBC = CW'(3);
    localparam logic [CW-1:0] A_INC  = CW'(4);
    localparam logic [CW-1:0] A_DEC  = CW'(5);
    localparam logic [CW-1:0] A_CMP  = CW'(8);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [CW-1:0] A_MUL  = CW'(9);
`endif
    localparam logic [CW-1:0] L_AND  = CW'(0);
    localparam logic [CW-1:0] L_NAND = CW'(1);
    localparam logic [CW-1:0] L_OR   = CW'(2);
    localparam logic [CW-1:0] L_NOR  = CW'(3);
    localparam logic [CW-1:0] L_XOR  = CW'(4);
    localparam logic [CW-1:0] L_XNOR = CW'(5);
    localparam logic [CW-1:0] L_NOTA = CW'(6);
    localparam logic [CW-1:0] L_NOTB = CW'(7);
    localparam logic [CW-1:0] L_SHR1 = CW'(8);
    localparam logic [CW-1:0] L_SHL1 = CW'(9);
    localparam logic [CW-1:0] L_ROL  = CW'(12);
    localparam logic [CW-1:0] L_ROR  = CW'(13);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_A,
        S_WAIT_B,
        S_EXEC
`ifdef ALU_SEQ_MUL_EN
        , S_MUL1,
        S_MUL2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d, mode_q, mode_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    logic [2*DW-1:0] res_q, res_d;
    logic            cout_q, cout_d, oflow_q, oflow_d;
    logic            g_q, g_d, e_q, e_d, l_q, l_d;
    logic            err_q, err_d, out_valid_q, out_valid_d, busy_q, busy_d;
`ifdef ALU_SEQ_MUL_EN
    logic [2*DW-1:0] prod_q, prod_d;
    logic            alu_mul;
`endif

    logic [2*DW-1:0] alu_res;
    logic            alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err, alu_arith;
    logic [DW:0]     ua, ub, cin_w, sum_w, sa, sb, sx_w;
    logic [SW:0]     amt_w, rot_w;
    logic [2*DW-1:0] rol_w, ror_w;
    logic            single_op;

    // Commands that need only OPA; decided on the live inputs while idle
    always_comb begin
        single_op = 1'b0;
        if (bus.MODE) begin
            single_op = (bus.CMD == A_INC) || (bus.CMD == A_DEC);
        end else begin
            single_op = (bus.CMD == L_NOTA) || (bus.CMD == L_SHR1) || (bus.CMD == L_SHL1);
        end
    end

    // Result and flags of the captured operation; COUT/OFLOW only for the add/sub family
    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_e     = 1'b0;
        alu_l     = 1'b0;
        alu_err   = 1'b0;
        alu_arith = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        alu_mul   = 1'b0;
`endif
        ua    = {1'b0, a_q};
        ub    = {1'b0, b_q};
        sa    = {a_q[DW-1], a_q};
        sb    = {b_q[DW-1], b_q};
        cin_w = {{DW{1'b0}}, cin_q};
        sum_w = '0;
        sx_w  = '0;
        // Rotate amount folded into 0..DW-1 so non power-of-two widths still rotate
        amt_w = {1'b0, b_q[SW-1:0]};
        rot_w = (amt_w >= (SW+1)'(DW)) ? amt_w - (SW+1)'(DW) : amt_w;
        rol_w = {a_q, a_q} << rot_w;
        ror_w = {a_q, a_q} >> rot_w;
        if (mode_q) begin
            case (cmd_q)
                A_ADD:  begin sum_w = ua + ub;         sx_w = sa + sb;         alu_arith = 1'b1; end
                A_SUB:  begin sum_w = ua - ub;         sx_w = sa - sb;         alu_arith = 1'b1; end
                A_ADDC: begin sum_w = ua + ub + cin_w; sx_w = sa + sb + cin_w; alu_arith = 1'b1; end
                A_SUBC: begin sum_w = ua - ub - cin_w; sx_w = sa - sb - cin_w; alu_arith = 1'b1; end
                A_INC:  alu_res = {{DW{1'b0}}, a_q + DW'(1)};
                A_DEC:  alu_res = {{DW{1'b0}}, a_q - DW'(1)};
                A_CMP:  begin
                    alu_g = (a_q > b_q);
                    alu_e = (a_q == b_q);
                    alu_l = (a_q < b_q);
                end
`ifdef ALU_SEQ_MUL_EN
                A_MUL:  alu_mul = 1'b1;
`endif
                default: alu_err = 1'b1;
            endcase
            if (alu_arith) begin
                alu_res   = {{DW{1'b0}}, sum_w[DW-1:0]};
                alu_cout  = sum_w[DW];
                alu_oflow = sx_w[DW] ^ sx_w[DW-1];
            end
        end else begin
            case (cmd_q)
                L_AND:  alu_res = {{DW{1'b0}}, a_q & b_q};
                L_NAND: alu_res = {{DW{1'b0}}, ~(a_q & b_q)};
                L_OR:   alu_res = {{DW{1'b0}}, a_q | b_q};
                L_NOR:  alu_res = {{DW{1'b0}}, ~(a_q | b_q)};
                L_XOR:  alu_res = {{DW{1'b0}}, a_q ^ b_q};
                L_XNOR: alu_res = {{DW{1'b0}}, ~(a_q ^ b_q)};
                L_NOTA: alu_res = {{DW{1'b0}}, ~a_q};
                L_NOTB: alu_res = {{DW{1'b0}}, ~b_q};
                L_SHR1: alu_res = {{DW{1'b0}}, a_q >> 1};
                L_SHL1: alu_res = {{DW{1'b0}}, a_q << 1};
                L_ROL:  begin alu_res = {{DW{1'b0}}, rol_w[2*DW-1:DW]}; alu_err = |b_q[DW-1:SW]; end
                L_ROR:  begin alu_res = {{DW{1'b0}}, ror_w[DW-1:0]};    alu_err = |b_q[DW-1:SW]; end
                default: alu_err = 1'b1;
            endcase
        end
    end

    // Sequencer: operand capture, timeout, execute and result register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        res_d       = res_q;
        cout_d      = cout_q;
        oflow_d     = oflow_q;
        g_d         = g_q;
        e_d         = e_q;
        l_d         = l_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d      = prod_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.INP_VALID != 2'b00) begin
                    mode_d = bus.MODE;
                    cmd_d  = bus.CMD;
                    cin_d  = bus.CIN;
                    cnt_d  = '0;
                    if (bus.INP_VALID[0]) a_d = bus.OPA;
                    if (bus.INP_VALID[1]) b_d = bus.OPB;
                    case (bus.INP_VALID)
                        2'b11:   state_d = S_EXEC;
                        2'b01:   state_d = single_op ? S_EXEC : S_WAIT_B;
                        default: state_d = S_WAIT_A;
                    endcase
                end
            end
            S_WAIT_A, S_WAIT_B: begin
                if ((state_q == S_WAIT_A) && bus.INP_VALID[0]) begin
                    a_d     = bus.OPA;
                    state_d = S_EXEC;
                end else if ((state_q == S_WAIT_B) && bus.INP_VALID[1]) begin
                    b_d     = bus.OPB;
                    state_d = S_EXEC;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    res_d       = '0;
                    cout_d      = 1'b0;
                    oflow_d     = 1'b0;
                    g_d         = 1'b0;
                    e_d         = 1'b0;
                    l_d         = 1'b0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
                if (alu_mul) begin
                    state_d = S_MUL1;
                end else
`endif
                begin
                    res_d       = alu_res;
                    cout_d      = alu_cout;
                    oflow_d     = alu_oflow;
                    g_d         = alu_g;
                    e_d         = alu_e;
                    l_d         = alu_l;
                    err_d       = alu_err;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL1: begin
                prod_d  = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
                state_d = S_MUL2;
            end
            S_MUL2: begin
                res_d       = prod_q;
                cout_d      = 1'b0;
                oflow_d     = 1'b0;
                g_d         = 1'b0;
                e_d         = 1'b0;
                l_d         = 1'b0;
                err_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers; CE low freezes everything
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            oflow_q     <= 1'b0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q      <= '0;
`endif
        end else if (bus.CE) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            oflow_q     <= oflow_d;
            g_q         <= g_d;
            e_q         <= e_d;
            l_q         <= l_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q      <= prod_d;
`endif
        end
    end

    assign bus.RES       = res_q;
    assign bus.COUT      = cout_q;
    assign bus.OFLOW     = oflow_q;
    assign bus.G         = g_q;
    assign bus.E         = e_q;
    assign bus.L         = l_q;
    assign bus.ERR       = err_q;
    // A pending pulse is masked while CE is low and shows again once CE returns
    assign bus.OUT_VALID = out_valid_q & bus.CE;
    assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized self-checking bench for alu_seq_core
module tb_alu_seq_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    alu_seq_core_if #(.DW(8), .CW(4)) bus ();
    alu_seq_core #(.DW(8), .CW(4), .TIMEOUT(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic cout, oflow, g, e, l, err;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.OPA  = 8'($urandom);
        bus.OPB  = 8'($urandom);
        bus.CMD  = 4'($urandom);
        bus.MODE = 1'($urandom);
        bus.CIN  = 1'($urandom);
    endtask

    function automatic bit single_op(input bit mode, input int cmd);
        return mode ? (cmd == 4 || cmd == 5) : (cmd == 6 || cmd == 8 || cmd == 9);
    endfunction

    function automatic exp_t model(input bit mode, input int cmd, input int a, input int b, input bit cin);
        exp_t x;
        int r, s, sa, sb, n;
        x  = '0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        n  = b % 8;
        r  = 0;
        s  = 0;
        if (mode) begin
            case (cmd)
                0: begin r = a + b;       s = sa + sb;       x.cout = (r > 255); end
                1: begin r = a - b;       s = sa - sb;       x.cout = (r < 0);   end
                2: begin r = a + b + cin; s = sa + sb + cin; x.cout = (r > 255); end
                3: begin r = a - b - cin; s = sa - sb - cin; x.cout = (r < 0);   end
                4: x.res = 16'((a + 1) & 255);
                5: x.res = 16'((a - 1) & 255);
                8: begin x.g = (a > b); x.e = (a == b); x.l = (a < b); end
`ifdef ALU_SEQ_MUL_EN
                9: x.res = 16'(a * b);
`endif
                default: x.err = 1'b1;
            endcase
            if (cmd <= 3) begin
                x.res   = 16'(r & 255);
                x.oflow = (s > 127) || (s < -128);
            end
        end else begin
            case (cmd)
                0:  x.res = 16'(a & b);
                1:  x.res = 16'(~(a & b) & 255);
                2:  x.res = 16'(a | b);
                3:  x.res = 16'(~(a | b) & 255);
                4:  x.res = 16'(a ^ b);
                5:  x.res = 16'(~(a ^ b) & 255);
                6:  x.res = 16'(~a & 255);
                7:  x.res = 16'(~b & 255);
                8:  x.res = 16'(a >> 1);
                9:  x.res = 16'((a << 1) & 255);
                12: begin x.res = 16'(((a << n) | (a >> (8 - n))) & 255); x.err = (b >= 8); end
                13: begin x.res = 16'(((a >> n) | (a << (8 - n))) & 255); x.err = (b >= 8); end
                default: x.err = 1'b1;
            endcase
        end
        return x;
    endfunction

    // order: 0 both operands together, 1 OPA first, 2 OPB first; gap idle cycles before the second operand
    task automatic run_txn(input bit mode, input int cmd, input int a, input int b, input bit cin,
                           input int order, input int gap);
        exp_t x;
        int lat, cnt;
        x   = model(mode, cmd, a, b, cin);
        lat = 1;
`ifdef ALU_SEQ_MUL_EN
        if (mode && cmd == 9) lat = 3;
`endif
        bus.MODE = mode;
        bus.CMD  = 4'(cmd);
        bus.CIN  = cin;
        if (order == 0) begin
            bus.INP_VALID = 2'b11;
            bus.OPA = 8'(a);
            bus.OPB = 8'(b);
            tick();
        end else begin
            bus.INP_VALID = (order == 1) ? 2'b01 : 2'b10;
            bus.OPA = (order == 1) ? 8'(a) : 8'($urandom);
            bus.OPB = (order == 1) ? 8'($urandom) : 8'(b);
            tick();
            if (!(order == 1 && single_op(mode, cmd))) begin
                scramble();
                bus.INP_VALID = 2'b00;
                repeat (gap) tick();
                chk("busy_wait", 32'(bus.BUSY), 32'd1);
                bus.INP_VALID = (order == 1) ? 2'b10 : 2'b01;
                if (order == 1) bus.OPB = 8'(b);
                else            bus.OPA = 8'(a);
                tick();
            end
        end
        scramble();
        bus.INP_VALID = 2'b00;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.OUT_VALID && cnt < 8);
        chk("latency", 32'(cnt), 32'(lat));
        chk("res",   32'(bus.RES),   32'(x.res));
        chk("cout",  32'(bus.COUT),  32'(x.cout));
        chk("oflow", 32'(bus.OFLOW), 32'(x.oflow));
        chk("gel",   {29'd0, bus.G, bus.E, bus.L}, {29'd0, x.g, x.e, x.l});
        chk("err",   32'(bus.ERR),   32'(x.err));
        chk("busy_done", 32'(bus.BUSY), 32'd0);
        tick();
        chk("ov_clear", 32'(bus.OUT_VALID), 32'd0);
        chk("res_hold", 32'(bus.RES), 32'(x.res));
    endtask

    initial begin
        int cnt;
        bus.CE = 1'b1;
        bus.INP_VALID = 2'b00;
        scramble();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_res", 32'(bus.RES), 32'd0);
        chk("rst_flags", {26'd0, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR}, 32'd0);
        chk("rst_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);

        run_txn(1'b1, 0, 8'hFF, 8'h01, 1'b0, 0, 0);
        run_txn(1'b1, 1, 8'h10, 8'h05, 1'b0, 1, 4);
        run_txn(1'b1, 2, 8'h7F, 8'h00, 1'b1, 2, 15);
        run_txn(1'b1, 9, 8'h0F, 8'h0F, 1'b0, 0, 0);
        run_txn(1'b1, 8, 8'h42, 8'h42, 1'b0, 0, 0);
        run_txn(1'b1, 4, 8'hFF, 8'h00, 1'b0, 1, 0);
        run_txn(1'b0, 7, 8'h00, 8'h5A, 1'b0, 0, 0);

        bus.MODE = 1'b1;
        bus.CMD = 4'd0;
        bus.OPA = 8'h33;
        bus.INP_VALID = 2'b01;
        tick();
        bus.INP_VALID = 2'b00;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.OUT_VALID && cnt < 40);
        chk("timeout_lat", 32'(cnt), 32'd16);
        chk("timeout_err", 32'(bus.ERR), 32'd1);
        chk("timeout_res", 32'(bus.RES), 32'd0);
        chk("timeout_busy", 32'(bus.BUSY), 32'd0);
        tick();

        bus.MODE = 1'b1;
        bus.CMD = 4'd0;
        bus.OPA = 8'h03;
        bus.OPB = 8'h04;
        bus.INP_VALID = 2'b11;
        tick();
        bus.INP_VALID = 2'b00;
        bus.CE = 1'b0;
        repeat (3) begin
            tick();
            chk("ce_hold_ov", 32'(bus.OUT_VALID), 32'd0);
            chk("ce_hold_busy", 32'(bus.BUSY), 32'd1);
        end
        bus.CE = 1'b1;
        tick();
        chk("ce_resume_ov", 32'(bus.OUT_VALID), 32'd1);
        chk("ce_resume_res", 32'(bus.RES), 32'd7);
        bus.CE = 1'b0;
        #1;
        chk("ce_mask_ov", 32'(bus.OUT_VALID), 32'd0);
        tick();
        chk("ce_mask_ov2", 32'(bus.OUT_VALID), 32'd0);
        chk("ce_mask_res", 32'(bus.RES), 32'd7);
        bus.CE = 1'b1;
        #1;
        chk("ce_pulse_back", 32'(bus.OUT_VALID), 32'd1);
        tick();
        chk("ce_pulse_end", 32'(bus.OUT_VALID), 32'd0);

        run_txn(1'b0, 12, 8'h81, 8'h11, 1'b0, 0, 0);

        bus.MODE = 1'b1;
        bus.CMD = 4'd9;
        bus.OPA = 8'h0F;
        bus.OPB = 8'h0F;
        bus.INP_VALID = 2'b11;
        tick();
        bus.INP_VALID = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_res", 32'(bus.RES), 32'd0);
        chk("mid_rst_flags", {26'd0, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR}, 32'd0);
        chk("mid_rst_ov", 32'(bus.OUT_VALID), 32'd0);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        tick();
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            if (bus.OUT_VALID) cnt++;
        end
        chk("post_rst_no_ov", 32'(cnt), 32'd0);

        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            run_txn(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)),
                    1'($urandom), int'($urandom_range(0, 2)), gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
